// File: rtl/pixel_matcher_pkg.sv
// Shared types and elaboration helpers for the pixel matcher.
// Reference values are plain parameters of the top; this only carries common definitions.
package pixel_matcher_pkg;

    typedef logic [1:0] match_id_t;

    // True when v is representable in n unsigned bits.
    function automatic bit ref_fits(longint unsigned v, int n);
        if (n >= 64) return 1'b1;
        return (v >> n) == 64'd0;
    endfunction

endpackage

// File: rtl/pixel_matcher_if.sv
// Sample/result bundle between pixel capture and the cube-colour decision logic.
// The capture side drives value; the matcher returns match/match_id one clock later.
interface pixel_matcher_if #(
    parameter int N = 8
);
    import pixel_matcher_pkg::*;

    logic [N-1:0] value;
    logic         match;
    match_id_t    match_id;

    modport master (output value, input match, input match_id);
    modport slave  (input value, output match, output match_id);

endinterface

// File: rtl/pixel_matcher_eq_cmp.sv
// Parameterised N-bit unsigned equality comparator.
// Pure combinational; instantiated once per reference value.
module pixel_eq_cmp #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         eq
);

    assign eq = (a == b);

endmodule

// File: rtl/pixel_matcher.sv
// Registered classifier: flags which of three fixed references the last sample equals.
// Lowest-indexed reference wins when parameters duplicate.
module pixel_matcher
    import pixel_matcher_pkg::*;
#(
    parameter int          N      = 8,
    parameter int unsigned VALUE1 = 23,
    parameter int unsigned VALUE2 = 70,
    parameter int unsigned VALUE3 = 117
) (
    input  logic              clock,
    input  logic              reset,
    pixel_matcher_if.slave    bus
);

    localparam match_id_t ID_NONE = 2'd0;
    localparam match_id_t ID_V1   = 2'd1;
    localparam match_id_t ID_V2   = 2'd2;
    localparam match_id_t ID_V3   = 2'd3;

    localparam logic [N-1:0] REF1 = N'(VALUE1);
    localparam logic [N-1:0] REF2 = N'(VALUE2);
    localparam logic [N-1:0] REF3 = N'(VALUE3);

    if (!ref_fits(longint'(VALUE1), N)) begin : g_value1_range
        $error("pixel_matcher: VALUE1 does not fit in N bits");
    end
    if (!ref_fits(longint'(VALUE2), N)) begin : g_value2_range
        $error("pixel_matcher: VALUE2 does not fit in N bits");
    end
    if (!ref_fits(longint'(VALUE3), N)) begin : g_value3_range
        $error("pixel_matcher: VALUE3 does not fit in N bits");
    end

    logic      eq1, eq2, eq3;
    match_id_t id_next;

    pixel_eq_cmp #(.N(N)) u_cmp1 (.a(bus.value), .b(REF1), .eq(eq1));
    pixel_eq_cmp #(.N(N)) u_cmp2 (.a(bus.value), .b(REF2), .eq(eq2));
    pixel_eq_cmp #(.N(N)) u_cmp3 (.a(bus.value), .b(REF3), .eq(eq3));

    always_comb begin
        id_next = ID_NONE;
        if (eq1)      id_next = ID_V1;
        else if (eq2) id_next = ID_V2;
        else if (eq3) id_next = ID_V3;
    end

    // match is derived from the same encoded id so the two outputs cannot disagree.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bus.match    <= 1'b0;
            bus.match_id <= ID_NONE;
        end else begin
            bus.match    <= (id_next != ID_NONE);
            bus.match_id <= id_next;
        end
    end

endmodule

// File: tb/tb_pixel_matcher.sv
// Directed, table-driven bench for pixel_matcher: default references plus a duplicate-reference instance.
module tb_pixel_matcher;

    typedef struct {
        logic [7:0] value;
        logic       m;
        logic [1:0] id;
    } vec_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clock = ~clock;

    pixel_matcher_if #(.N(8)) bus ();
    pixel_matcher_if #(.N(8)) pbus ();

    pixel_matcher #(.N(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    pixel_matcher #(.N(8), .VALUE1(50), .VALUE2(50), .VALUE3(117)) dut_pri (
        .clock (clock),
        .reset (reset),
        .bus   (pbus.slave)
    );

    task automatic check(input string name, input logic got_m, input logic [1:0] got_id,
                         input logic exp_m, input logic [1:0] exp_id);
        vectors++;
        if (got_m !== exp_m || got_id !== exp_id) begin
            miscompares++;
            $display("FAIL %s: got match=%b id=%0d, expected match=%b id=%0d",
                     name, got_m, got_id, exp_m, exp_id);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    vec_t vecs[12];
    vec_t seq[5];
    vec_t pri[4];
    logic       prev_m;
    logic [1:0] prev_id;

    initial begin
        vecs[0]  = '{8'd117, 1'b1, 2'd3};
        vecs[1]  = '{8'd70,  1'b1, 2'd2};
        vecs[2]  = '{8'd48,  1'b0, 2'd0};
        vecs[3]  = '{8'd116, 1'b0, 2'd0};
        vecs[4]  = '{8'd22,  1'b0, 2'd0};
        vecs[5]  = '{8'd24,  1'b0, 2'd0};
        vecs[6]  = '{8'd69,  1'b0, 2'd0};
        vecs[7]  = '{8'd71,  1'b0, 2'd0};
        vecs[8]  = '{8'd118, 1'b0, 2'd0};
        vecs[9]  = '{8'd23,  1'b1, 2'd1};
        vecs[10] = '{8'd0,   1'b0, 2'd0};
        vecs[11] = '{8'd255, 1'b0, 2'd0};

        seq[0] = '{8'd23,  1'b1, 2'd1};
        seq[1] = '{8'd48,  1'b0, 2'd0};
        seq[2] = '{8'd117, 1'b1, 2'd3};
        seq[3] = '{8'd116, 1'b0, 2'd0};
        seq[4] = '{8'd70,  1'b1, 2'd2};

        pri[0] = '{8'd50,  1'b1, 2'd1};
        pri[1] = '{8'd117, 1'b1, 2'd3};
        pri[2] = '{8'd23,  1'b0, 2'd0};
        pri[3] = '{8'd70,  1'b0, 2'd0};

        // Reset held with a matching value on the input.
        bus.value  = 8'd23;
        pbus.value = 8'd0;
        #1;
        check("reset_immediate", bus.match, bus.match_id, 1'b0, 2'd0);
        tick();
        check("reset_held", bus.match, bus.match_id, 1'b0, 2'd0);
        @(negedge clock);
        reset = 1'b0;
        tick();
        check("reset_release", bus.match, bus.match_id, 1'b1, 2'd1);

        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_23", bus.match, bus.match_id, 1'b1, 2'd1);
        end

        foreach (vecs[i]) begin
            bus.value = vecs[i].value;
            tick();
            check($sformatf("vec_%0d", vecs[i].value), bus.match, bus.match_id,
                  vecs[i].m, vecs[i].id);
        end

        // Back-to-back samples: outputs must lag the input by exactly one edge.
        bus.value = 8'd0;
        tick();
        prev_m  = 1'b0;
        prev_id = 2'd0;
        foreach (seq[i]) begin
            bus.value = seq[i].value;
            #2;
            check($sformatf("seq_pre_%0d", i), bus.match, bus.match_id, prev_m, prev_id);
            tick();
            check($sformatf("seq_post_%0d", i), bus.match, bus.match_id, seq[i].m, seq[i].id);
            prev_m  = seq[i].m;
            prev_id = seq[i].id;
        end

        foreach (pri[i]) begin
            pbus.value = pri[i].value;
            tick();
            check($sformatf("pri_%0d", pri[i].value), pbus.match, pbus.match_id,
                  pri[i].m, pri[i].id);
        end

        // Asynchronous reset between edges while a match is displayed.
        bus.value = 8'd70;
        tick();
        check("mid_pre", bus.match, bus.match_id, 1'b1, 2'd2);
        #2;
        reset = 1'b1;
        #1;
        check("mid_async_clear", bus.match, bus.match_id, 1'b0, 2'd0);
        tick();
        check("mid_held", bus.match, bus.match_id, 1'b0, 2'd0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("mid_released_no_edge", bus.match, bus.match_id, 1'b0, 2'd0);
        tick();
        check("mid_recover", bus.match, bus.match_id, 1'b1, 2'd2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
